// File: rtl/ring_pkg.sv
// rtl/ring_pkg.sv - shared types and helpers for the ring phase monitor
// Contents:
//   state_t    monitor FSM states (IDLE, TRACK, LOCKED, FAULT)
//   ERR_*      err_code values reported on a violation
//   rot_next   right-rotate the low w bits of a word by one position
package ring_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2,
        FAULT  = 2'd3
    } state_t;

    localparam logic [1:0] ERR_NONE   = 2'b00;
    localparam logic [1:0] ERR_ONEHOT = 2'b01;
    localparam logic [1:0] ERR_ORDER  = 2'b10;

    // Operates on a 32-bit container so one function serves any ring width
    // up to 32. Bits at and above w are returned as zero, so comparing the
    // result against a zero-extended ring word is exact.
    function automatic logic [31:0] rot_next(input logic [31:0] word, input int w);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 31; i++) begin
            if (i < w - 1) begin
                r[i] = word[i + 1];
            end
        end
        r[w - 1] = word[0];
        return r;
    endfunction

endpackage

// File: rtl/onehot_enc.sv
// rtl/onehot_enc.sv - combinational one-hot check and binary index encoder
// Ports:
//   word       in   WIDTH  word to examine
//   is_onehot  out  1      exactly one bit of word is set
//   index      out  PW     position of the set bit (highest set bit if not one-hot)
module onehot_enc #(
    parameter int WIDTH = 4,
    parameter int PW    = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] word,
    output logic             is_onehot,
    output logic [PW-1:0]    index
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0] ones;

    always_comb begin
        ones  = '0;
        index = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (word[i]) begin
                ones  = ones + CW'(1);
                index = PW'(i);
            end
        end
        is_onehot = (ones == CW'(1));
    end

endmodule

// File: rtl/ring_phase_monitor.sv
// rtl/ring_phase_monitor.sv - checks a one-hot ring word for legal rotation, locks and counts revolutions
// Ports:
//   clk          in   1      clock, rising edge
//   reset        in   1      asynchronous active-low reset
//   r_in         in   WIDTH  ring word sampled every edge
//   clr          in   1      synchronous clear back to IDLE, zeroes rev_cnt and fault
//   phase        out  PW     index of the set bit of the last one-hot sample
//   phase_valid  out  1      phase reflects a checked one-hot sample
//   locked       out  1      monitor is in LOCKED
//   rev_cnt      out  REV_W  revolutions completed while locked (wraps)
//   fault        out  1      sticky sequencing fault
//   err_pulse    out  1      one-cycle pulse on a detected violation
//   err_code     out  2      cause of the last violation
module ring_phase_monitor
    import ring_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int PW       = $clog2(WIDTH),
    parameter int REV_W    = 8,
    parameter int LOCK_CNT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] r_in,
    input  logic             clr,
    output logic [PW-1:0]    phase,
    output logic             phase_valid,
    output logic             locked,
    output logic [REV_W-1:0] rev_cnt,
    output logic             fault,
    output logic             err_pulse,
    output logic [1:0]       err_code
);

    localparam int GW = $clog2(LOCK_CNT + 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [GW-1:0]    good_q, good_d, good_inc;
    logic [PW-1:0]    phase_d;
    logic             pv_d, locked_d, fault_d, ep_d;
    logic [REV_W-1:0] rev_d;
    logic [1:0]       ec_d;

    logic             is_oh;
    logic [PW-1:0]    idx;
    logic             adv, hold;

    onehot_enc #(.WIDTH(WIDTH), .PW(PW)) u_enc (
        .word      (r_in),
        .is_onehot (is_oh),
        .index     (idx)
    );

    assign hold     = (r_in == prev_q);
    assign adv      = (rot_next(32'(prev_q), WIDTH) == 32'(r_in));
    assign good_inc = good_q + GW'(1);

    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        good_d  = good_q;
        phase_d = phase;
        pv_d    = phase_valid;
        rev_d   = rev_cnt;
        fault_d = fault;
        ep_d    = 1'b0;
        ec_d    = err_code;

        if (clr) begin
            state_d = IDLE;
            good_d  = '0;
            rev_d   = '0;
            fault_d = 1'b0;
            ec_d    = ERR_NONE;
            pv_d    = 1'b0;
        end else begin
            if (state_q != FAULT) begin
                pv_d = is_oh;
                if (is_oh) begin
                    phase_d = idx;
                end
            end

            case (state_q)
                IDLE: begin
                    if (is_oh) begin
                        state_d = TRACK;
                        prev_d  = r_in;
                        good_d  = '0;
                    end
                end
                TRACK: begin
                    if (is_oh && adv) begin
                        prev_d = r_in;
                        good_d = good_inc;
                        if (good_inc == GW'(LOCK_CNT)) begin
                            state_d = LOCKED;
                        end
                    end else if (!(is_oh && hold)) begin
                        // Loss of sequence before lock is not an error, just a restart.
                        state_d = IDLE;
                        good_d  = '0;
                    end
                end
                LOCKED: begin
                    if (!is_oh) begin
                        state_d = FAULT;
                        ec_d    = ERR_ONEHOT;
                        ep_d    = 1'b1;
                        fault_d = 1'b1;
                        pv_d    = 1'b0;
                    end else if (adv) begin
                        prev_d = r_in;
                        // Leaving phase 0 means wrapping to the top bit: one revolution done.
                        if (prev_q[0]) begin
                            rev_d = rev_cnt + REV_W'(1);
                        end
                    end else if (!hold) begin
                        state_d = FAULT;
                        ec_d    = ERR_ORDER;
                        ep_d    = 1'b1;
                        fault_d = 1'b1;
                        pv_d    = 1'b0;
                    end
                end
                FAULT: begin
                    pv_d = 1'b0;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            prev_q      <= '0;
            good_q      <= '0;
            phase       <= '0;
            phase_valid <= 1'b0;
            locked      <= 1'b0;
            rev_cnt     <= '0;
            fault       <= 1'b0;
            err_pulse   <= 1'b0;
            err_code    <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            good_q      <= good_d;
            phase       <= phase_d;
            phase_valid <= pv_d;
            locked      <= locked_d;
            rev_cnt     <= rev_d;
            fault       <= fault_d;
            err_pulse   <= ep_d;
            err_code    <= ec_d;
        end
    end

endmodule

// File: tb/tb_ring_phase_monitor.sv
// tb/tb_ring_phase_monitor.sv - self-checking bench for ring_phase_monitor
module tb_ring_phase_monitor;

    localparam int WIDTH    = 4;
    localparam int PW       = 2;
    localparam int REV_W    = 2;
    localparam int LOCK_CNT = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             clr;
    logic [WIDTH-1:0] r_in;
    logic [PW-1:0]    phase;
    logic             phase_valid;
    logic             locked;
    logic [REV_W-1:0] rev_cnt;
    logic             fault;
    logic             err_pulse;
    logic [1:0]       err_code;

    int tests = 0;
    int fails = 0;

    logic [9:0] sb[$];
    logic [9:0] got;
    logic [9:0] obs;

    ring_phase_monitor #(
        .WIDTH    (WIDTH),
        .REV_W    (REV_W),
        .LOCK_CNT (LOCK_CNT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .r_in        (r_in),
        .clr         (clr),
        .phase       (phase),
        .phase_valid (phase_valid),
        .locked      (locked),
        .rev_cnt     (rev_cnt),
        .fault       (fault),
        .err_pulse   (err_pulse),
        .err_code    (err_code)
    );

    always #5 clk = ~clk;

    // Packed view: {phase, phase_valid, locked, rev_cnt, fault, err_pulse, err_code}
    assign obs = {phase, phase_valid, locked, rev_cnt, fault, err_pulse, err_code};

    function automatic logic [9:0] e(input int ph, input int pv, input int lk,
                                     input int rev, input int f, input int ep, input int ec);
        return {2'(ph), 1'(pv), 1'(lk), 2'(rev), 1'(f), 1'(ep), 2'(ec)};
    endfunction

    task automatic drive(input logic [3:0] r, input logic c, input logic [9:0] exp);
        r_in = r;
        clr  = c;
        sb.push_back(exp);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        clr   = 1'b0;
        r_in  = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (obs !== 10'b0) begin
            fails++;
            $display("FAIL reset_state got %b expected %b", obs, 10'b0);
        end
        reset = 1'b1;
    endtask

    task automatic test_lock();
        logic [3:0] rs [5];
        int         ph [5];
        rs = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000};
        ph = '{3, 2, 1, 0, 3};
        for (int i = 0; i < 5; i++) begin
            drive(rs[i], 1'b0, e(ph[i], 1, (i == 4) ? 1 : 0, 0, 0, 0, 0));
            got = sb.pop_front();
            tests++;
            if (obs !== got) begin
                fails++;
                $display("FAIL lock edge %0d got %b expected %b", i + 1, obs, got);
            end
        end
    endtask

    task automatic test_rev_wrap();
        logic [3:0] rs [4];
        int         ph [4];
        rs = '{4'b0100, 4'b0010, 4'b0001, 4'b1000};
        ph = '{2, 1, 0, 3};
        for (int rv = 1; rv <= 4; rv++) begin
            for (int s = 0; s < 4; s++) begin
                drive(rs[s], 1'b0, e(ph[s], 1, 1, (s == 3) ? (rv % 4) : ((rv - 1) % 4), 0, 0, 0));
                got = sb.pop_front();
                tests++;
                if (obs !== got) begin
                    fails++;
                    $display("FAIL rev_wrap rev %0d step %0d got %b expected %b", rv, s, obs, got);
                end
            end
        end
    endtask

    task automatic test_order_fault();
        logic [3:0] rs [4];
        logic [9:0] ex [4];
        rs = '{4'b0100, 4'b0001, 4'b1000, 4'b0100};
        ex[0] = e(2, 1, 1, 0, 0, 0, 0);
        ex[1] = e(0, 0, 0, 0, 1, 1, 2);
        ex[2] = e(0, 0, 0, 0, 1, 0, 2);
        ex[3] = e(0, 0, 0, 0, 1, 0, 2);
        for (int i = 0; i < 4; i++) begin
            drive(rs[i], 1'b0, ex[i]);
            got = sb.pop_front();
            tests++;
            if (obs !== got) begin
                fails++;
                $display("FAIL order_fault step %0d got %b expected %b", i, obs, got);
            end
        end
    endtask

    task automatic test_clr();
        drive(4'b0011, 1'b1, e(0, 0, 0, 0, 0, 0, 0));
        got = sb.pop_front();
        tests++;
        if (obs !== got) begin
            fails++;
            $display("FAIL clr_in_fault got %b expected %b", obs, got);
        end
    endtask

    task automatic test_onehot_fault();
        logic [3:0] rs [10];
        logic       cs [10];
        logic [9:0] ex [10];
        rs = '{4'b0010, 4'b0001, 4'b1000, 4'b0100, 4'b0010,
               4'b0001, 4'b1000, 4'b0110, 4'b0100, 4'b0011};
        cs = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        ex[0] = e(1, 1, 0, 0, 0, 0, 0);
        ex[1] = e(0, 1, 0, 0, 0, 0, 0);
        ex[2] = e(3, 1, 0, 0, 0, 0, 0);
        ex[3] = e(2, 1, 0, 0, 0, 0, 0);
        ex[4] = e(1, 1, 1, 0, 0, 0, 0);
        ex[5] = e(0, 1, 1, 0, 0, 0, 0);
        ex[6] = e(3, 1, 1, 1, 0, 0, 0);
        ex[7] = e(3, 0, 0, 1, 1, 1, 1);
        ex[8] = e(3, 0, 0, 1, 1, 0, 1);
        ex[9] = e(3, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            drive(rs[i], cs[i], ex[i]);
            got = sb.pop_front();
            tests++;
            if (obs !== got) begin
                fails++;
                $display("FAIL onehot_fault step %0d got %b expected %b", i, obs, got);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [3:0] rs [3];
        int         ph [3];
        rs = '{4'b1000, 4'b0100, 4'b0010};
        ph = '{3, 2, 1};
        for (int i = 0; i < 3; i++) begin
            drive(rs[i], 1'b0, e(ph[i], 1, 0, 0, 0, 0, 0));
            got = sb.pop_front();
            tests++;
            if (obs !== got) begin
                fails++;
                $display("FAIL async_pre step %0d got %b expected %b", i, obs, got);
            end
        end
        #2;
        reset = 1'b0;
        #1;
        tests++;
        if (obs !== 10'b0) begin
            fails++;
            $display("FAIL async_reset got %b expected %b", obs, 10'b0);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_hold_and_reverse();
        for (int i = 0; i < 10; i++) begin
            drive(4'b1000, 1'b0, e(3, 1, 0, 0, 0, 0, 0));
            got = sb.pop_front();
            tests++;
            if (obs !== got) begin
                fails++;
                $display("FAIL hold edge %0d got %b expected %b", i + 1, obs, got);
            end
        end
        drive(4'b0001, 1'b0, e(0, 1, 0, 0, 0, 0, 0));
        got = sb.pop_front();
        tests++;
        if (obs !== got) begin
            fails++;
            $display("FAIL reverse_in_track got %b expected %b", obs, got);
        end
        drive(4'b0010, 1'b0, e(1, 1, 0, 0, 0, 0, 0));
        got = sb.pop_front();
        tests++;
        if (obs !== got) begin
            fails++;
            $display("FAIL retrack got %b expected %b", obs, got);
        end
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain got %0d expected 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_rev_wrap();
        test_order_fault();
        test_clr();
        test_onehot_fault();
        test_async_reset();
        test_hold_and_reverse();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
